// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and data memory.
//
// Handshake: the master raises dmem_req together with dmem_we, dmem_addr,
// dmem_be and dmem_wdata and keeps all of them stable until it samples
// dmem_ack=1 on a rising clock edge. That edge completes the transfer; for a
// read, dmem_rdata is valid in the same cycle as dmem_ack. dmem_ack is only
// meaningful while dmem_req=1 and is ignored at any other time.
//
// Signals:
//   dmem_req    master->slave  transfer request
//   dmem_we     master->slave  1 = write, 0 = read
//   dmem_addr   master->slave  word-aligned byte address
//   dmem_be     master->slave  byte enables
//   dmem_wdata  master->slave  lane-steered write data
//   dmem_rdata  slave->master  read data, valid with dmem_ack
//   dmem_ack    slave->master  transfer complete
interface mem_access_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM-stage load/store unit. Launches one data-memory transfer per load or
// store over a req/ack bus, holds the pipeline while it is outstanding,
// steers store data into byte lanes and sign/zero-extends load data.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   MemRead_mem       load in MEM stage
//   MemWrite_mem      store in MEM stage (wins if both are set)
//   Funct3_mem        000 B, 001 H, 010 W, 100 BU, 101 HU
//   ALUResult_mem     effective byte address
//   MemWriteData_mem  right-aligned store data
//   MemDout_mem       registered, extended load data to MEM/WB
//   MemStall          hold the front of the pipeline
//   MisalignErr       one-cycle pulse: misaligned or illegal access
//   BusErr            one-cycle pulse: access timed out
//   o_state           FSM state (0 IDLE, 1 WAIT, 2 DONE) for observation
//   dmem              data-memory bus, master side
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 MemRead_mem,
    input  logic                 MemWrite_mem,
    input  logic [2:0]           Funct3_mem,
    input  logic [31:0]          ALUResult_mem,
    input  logic [31:0]          MemWriteData_mem,
    output logic [31:0]          MemDout_mem,
    output logic                 MemStall,
    output logic                 MisalignErr,
    output logic                 BusErr,
    output logic [1:0]           o_state,
    mem_access_stage_if.master   dmem
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic             r_req;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [3:0]       r_be;
    logic [31:0]      r_wdata;
    logic [31:0]      r_dout;
    logic             r_misalign;
    logic             r_buserr;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_f3;
    logic [1:0]       r_a;
    logic             r_load;

    logic             w_access;
    logic             w_store;
    logic [1:0]       w_a;
    logic             w_fault;
    logic             w_launch;
    logic             w_fault_hit;
    logic             w_timeout;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_ext;

    assign w_access = MemRead_mem | MemWrite_mem;
    assign w_store  = MemWrite_mem;
    assign w_a      = ALUResult_mem[1:0];

    // Illegal encodings and misalignment are both reported as MisalignErr.
    always_comb begin
        w_fault = 1'b0;
        case (Funct3_mem)
            3'b000, 3'b100: w_fault = 1'b0;
            3'b001, 3'b101: w_fault = w_a[0];
            3'b010:         w_fault = |w_a;
            default:        w_fault = 1'b1;
        endcase
        // There is no unsigned store.
        if (w_store && Funct3_mem[2]) begin
            w_fault = 1'b1;
        end
    end

    assign w_launch    = (r_state == IDLE) && w_access && !w_fault;
    assign w_fault_hit = (r_state == IDLE) && w_access && w_fault;
    // The counter is cleared on launch and counts WAIT cycles without ack,
    // so it holds TIMEOUT_CYCLES-1 during the last permitted WAIT cycle.
    assign w_timeout   = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Store lane steering; loads always read the whole word.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = 32'd0;
        if (w_store) begin
            case (Funct3_mem[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << w_a;
                    w_wdata = {4{MemWriteData_mem[7:0]}};
                end
                2'b01: begin
                    w_be    = w_a[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{MemWriteData_mem[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = MemWriteData_mem;
                end
            endcase
        end
    end

    // Load extraction uses the size/offset captured at launch, because the
    // EX/MEM inputs are only guaranteed stable while MemStall is high.
    always_comb begin
        w_byte = 8'd0;
        case (r_a)
            2'd0:    w_byte = dmem.dmem_rdata[7:0];
            2'd1:    w_byte = dmem.dmem_rdata[15:8];
            2'd2:    w_byte = dmem.dmem_rdata[23:16];
            default: w_byte = dmem.dmem_rdata[31:24];
        endcase
        w_half = r_a[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
        case (r_f3)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_ext = {24'd0, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b101:  w_ext = {16'd0, w_half};
            default: w_ext = dmem.dmem_rdata;
        endcase
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_launch) w_next = WAIT;
            WAIT:    if (dmem.dmem_ack || w_timeout) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Datapath and bus registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= 32'd0;
            r_be       <= 4'd0;
            r_wdata    <= 32'd0;
            r_dout     <= 32'd0;
            r_misalign <= 1'b0;
            r_buserr   <= 1'b0;
            r_cnt      <= '0;
            r_f3       <= 3'd0;
            r_a        <= 2'd0;
            r_load     <= 1'b0;
        end else begin
            r_misalign <= w_fault_hit;
            r_buserr   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_launch) begin
                        r_req   <= 1'b1;
                        r_we    <= w_store;
                        r_addr  <= {ALUResult_mem[31:2], 2'b00};
                        r_be    <= w_be;
                        r_wdata <= w_wdata;
                        r_cnt   <= '0;
                        r_f3    <= Funct3_mem;
                        r_a     <= w_a;
                        r_load  <= !w_store;
                    end else if (w_fault_hit) begin
                        r_dout <= 32'd0;
                    end
                end
                WAIT: begin
                    if (dmem.dmem_ack) begin
                        r_req <= 1'b0;
                        if (r_load) begin
                            r_dout <= w_ext;
                        end
                    end else if (w_timeout) begin
                        r_req    <= 1'b0;
                        r_dout   <= 32'd0;
                        r_buserr <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // The launch cycle stalls combinationally so EX/MEM holds the access
    // until DONE; reset forces the stall low at once.
    assign MemStall    = !reset && (w_launch || (r_state == WAIT));
    assign MemDout_mem = r_dout;
    assign MisalignErr = r_misalign;
    assign BusErr      = r_buserr;
    assign o_state     = r_state;

    assign dmem.dmem_req   = r_req;
    assign dmem.dmem_we    = r_we;
    assign dmem.dmem_addr  = r_addr;
    assign dmem.dmem_be    = r_be;
    assign dmem.dmem_wdata = r_wdata;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  localparam int TO = 4;

  logic        clk;
  logic        reset;
  logic        MemRead_mem;
  logic        MemWrite_mem;
  logic [2:0]  Funct3_mem;
  logic [31:0] ALUResult_mem;
  logic [31:0] MemWriteData_mem;
  logic [31:0] MemDout_mem;
  logic        MemStall;
  logic        MisalignErr;
  logic        BusErr;
  logic [1:0]  o_state;

  mem_access_stage_if bus();

  mem_access_stage #(
    .TIMEOUT_CYCLES(TO),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .MemRead_mem(MemRead_mem),
    .MemWrite_mem(MemWrite_mem),
    .Funct3_mem(Funct3_mem),
    .ALUResult_mem(ALUResult_mem),
    .MemWriteData_mem(MemWriteData_mem),
    .MemDout_mem(MemDout_mem),
    .MemStall(MemStall),
    .MisalignErr(MisalignErr),
    .BusErr(BusErr),
    .o_state(o_state),
    .dmem(bus.master)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_dout = 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit model_fault(input bit wr, input logic [2:0] f3, input logic [31:0] addr);
    bit legal;
    int size;
    if (wr) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    if (!legal) return 1'b1;
    size = 1 << int'(f3[1:0]);
    return (int'(addr[1:0]) % size) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rd);
    int a;
    logic [31:0] v;
    a = int'(addr[1:0]);
    if (f3[1:0] == 2'd0) begin
      v = (rd >> (8 * a)) & 32'hFF;
      if (!f3[2] && v >= 32'd128) v = v | 32'hFFFF_FF00;
    end else if (f3[1:0] == 2'd1) begin
      v = (rd >> (16 * (a / 2))) & 32'hFFFF;
      if (!f3[2] && v >= 32'd32768) v = v | 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic [3:0] model_be(input bit wr, input logic [2:0] f3, input logic [31:0] addr);
    int a;
    a = int'(addr[1:0]);
    if (!wr) return 4'hF;
    if (f3[1:0] == 2'd0) return 4'(1 << a);
    if (f3[1:0] == 2'd1) return (a >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    if (f3[1:0] == 2'd0) return {24'd0, wd[7:0]} * 32'h0101_0101;
    if (f3[1:0] == 2'd1) return {16'd0, wd[15:0]} * 32'h0001_0001;
    return wd;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    MemRead_mem      = 1'b0;
    MemWrite_mem     = 1'b0;
    Funct3_mem       = 3'd0;
    ALUResult_mem    = 32'd0;
    MemWriteData_mem = 32'd0;
  endtask

  // One instruction in MEM; the memory acks in WAIT cycle nwait+1.
  task automatic run_op(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rdata, input int nwait);
    bit flt;
    bit timed_out;
    bit done;
    int stall;
    int c;
    flt       = model_fault(wr, f3, addr);
    timed_out = (nwait + 1) > TO;
    if (flt || (!wr && timed_out)) model_dout = 32'd0;
    else if (!wr) model_dout = model_load(f3, addr, rdata);
    exp_q.push_back(model_dout);

    @(negedge clk);
    MemRead_mem = rd; MemWrite_mem = wr; Funct3_mem = f3;
    ALUResult_mem = addr; MemWriteData_mem = wd;
    #1;
    if (flt) begin
      check("fault_stall", MemStall, 32'd0);
      @(negedge clk);
      drive_idle();
      #1;
      check("misalign_pulse", MisalignErr, 32'd1);
      check("fault_noreq", bus.dmem_req, 32'd0);
      check("fault_dout", MemDout_mem, exp_q.pop_front());
      @(negedge clk);
      #1;
      check("misalign_clear", MisalignErr, 32'd0);
      return;
    end

    check("launch_stall", MemStall, 32'd1);
    stall = 1;
    c = 0;
    done = 1'b0;
    while (!done && c < 40) begin
      @(negedge clk);
      c++;
      bus.dmem_ack   = (c == nwait + 1);
      bus.dmem_rdata = (c == nwait + 1) ? rdata : $urandom();
      #1;
      if (MemStall) begin
        stall++;
        check("wait_req", bus.dmem_req, 32'd1);
        check("wait_we", bus.dmem_we, {31'd0, wr});
        check("wait_addr", bus.dmem_addr, {addr[31:2], 2'b00});
        check("wait_be", bus.dmem_be, model_be(wr, f3, addr));
        if (wr) check("wait_wdata", bus.dmem_wdata, model_wdata(f3, wd));
      end else begin
        done = 1'b1;
      end
    end
    check("stall_bound", done, 32'd1);
    check("done_req", bus.dmem_req, 32'd0);
    check("done_dout", MemDout_mem, exp_q.pop_front());
    check("done_buserr", BusErr, {31'd0, timed_out});
    check("stall_cycles", stall, timed_out ? TO + 1 : nwait + 2);

    @(negedge clk);
    drive_idle();
    bus.dmem_ack = 1'b0;
    #1;
    check("idle_buserr", BusErr, 32'd0);
    check("idle_stall", MemStall, 32'd0);
  endtask

  task automatic reset_mid_wait();
    @(negedge clk);
    MemRead_mem = 1'b1; MemWrite_mem = 1'b0; Funct3_mem = 3'b010;
    ALUResult_mem = 32'h200; MemWriteData_mem = 32'd0;
    bus.dmem_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_pre_req", bus.dmem_req, 32'd1);
    reset = 1'b1;
    #1;
    check("rst_req", bus.dmem_req, 32'd0);
    check("rst_stall", MemStall, 32'd0);
    check("rst_dout", MemDout_mem, 32'd0);
    model_dout = 32'd0;
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    reset = 1'b0;
    bus.dmem_ack = 1'b1;
    bus.dmem_rdata = 32'hCAFE_F00D;
    #1;
    check("late_ack_req", bus.dmem_req, 32'd0);
    @(negedge clk);
    bus.dmem_ack = 1'b0;
    #1;
    check("late_ack_dout", MemDout_mem, 32'd0);
    check("late_ack_stall", MemStall, 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1;
    drive_idle();
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_dout0", MemDout_mem, 32'd0);
    check("rst_stall0", MemStall, 32'd0);
    check("rst_misalign0", MisalignErr, 32'd0);
    check("rst_buserr0", BusErr, 32'd0);
    check("rst_req0", bus.dmem_req, 32'd0);
    check("rst_we0", bus.dmem_we, 32'd0);
    check("rst_addr0", bus.dmem_addr, 32'd0);
    check("rst_be0", bus.dmem_be, 32'd0);
    check("rst_wdata0", bus.dmem_wdata, 32'd0);
    check("rst_state0", o_state, 32'd0);
    reset = 1'b0;

    // Directed cases.
    run_op(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'd0, 0);      // SW
    run_op(1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 32'h80FF_1234, 3);      // LB
    check("lb_value", MemDout_mem, 32'hFFFF_FF80);
    run_op(1'b1, 1'b0, 3'b101, 32'h102, 32'd0, 32'h8001_0000, 0);      // LHU
    check("lhu_value", MemDout_mem, 32'h0000_8001);
    run_op(1'b0, 1'b1, 3'b000, 32'h101, 32'h0000_00AB, 32'd0, 1);      // SB
    check("sb_keeps_dout", MemDout_mem, 32'h0000_8001);
    run_op(1'b1, 1'b0, 3'b010, 32'h102, 32'd0, 32'd0, 0);              // LW misaligned
    run_op(1'b1, 1'b0, 3'b010, 32'h108, 32'd0, 32'h1357_9BDF, 0);      // LW
    run_op(1'b1, 1'b0, 3'b010, 32'h104, 32'd0, 32'h1234_5678, TO);     // timeout
    run_op(1'b1, 1'b1, 3'b001, 32'h10E, 32'h0000_BEEF, 32'd0, 2);      // both set: SH
    run_op(1'b0, 1'b1, 3'b100, 32'h100, 32'h1, 32'd0, 0);              // illegal store
    run_op(1'b1, 1'b0, 3'b011, 32'h100, 32'd0, 32'd0, 0);              // illegal funct3
    reset_mid_wait();
    run_op(1'b1, 1'b0, 3'b001, 32'h302, 32'd0, 32'hF00F_1234, 0);      // LH after reset

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      int kind;
      kind = $urandom_range(1, 3);
      run_op(kind[0], kind[1], 3'($urandom_range(0, 7)), $urandom(), $urandom(), $urandom(),
             $urandom_range(0, TO + 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM-stage load/store unit between the EX/MEM pipeline register and the MEM/WB register (MRM_EB).
- Replaces the single-cycle DataRam with a req/ack data-memory bus.
- Generates byte enables and store-data lane steering, and sign/zero-extends load data into MemDout_mem.
- Holds the pipeline via MemStall while an access is outstanding, and flags misaligned, illegal and timed-out accesses.

Parameters:
TIMEOUT_CYCLES, 255, WAIT cycles without dmem_ack before a bus error is declared (1..2^CNT_W-1)
CNT_W, 8, width of the timeout counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
MemRead_mem  input  1  load in MEM stage
MemWrite_mem  input  1  store in MEM stage
Funct3_mem  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
ALUResult_mem  input  32  effective byte address
MemWriteData_mem  input  32  store data (rs2), right-aligned
MemDout_mem  output  32  extended load data to MEM/WB
MemStall  output  1  hold PC, IF/ID, ID/EX and EX/MEM; inject no bubble into MEM/WB
MisalignErr  output  1  one-cycle pulse, misaligned or illegal access
BusErr  output  1  one-cycle pulse, access timed out
dmem_req  output  1  bus request (registered)
dmem_we  output  1  1 = write
dmem_addr  output  32  word address: ALUResult_mem[31:2],2'b00
dmem_be  output  4  byte enables
dmem_wdata  output  32  lane-steered store data
dmem_rdata  input  32  read data, valid with dmem_ack
dmem_ack  input  1  transfer complete, sampled while dmem_req=1

Behaviour:
- Reset values, asynchronous:
  - state=IDLE.
  - dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, MemDout_mem = 0.
  - MisalignErr, BusErr = 0; counter = 0.
- Access: access = MemRead_mem | MemWrite_mem. If both are set, the access is a store.
- Fault check (combinational in IDLE):
  - H/HU with addr[0]=1 → fault.
  - W with addr[1:0]≠0 → fault.
  - Funct3 ∈ {011,110,111}, or a store with Funct3 ∈ {100,101} → fault.
- FSM states IDLE, WAIT, DONE.
- IDLE:
  - No access → MemStall=0, stay in IDLE.
  - Access with fault → MemStall=0; MisalignErr=1 next cycle for one cycle; no bus request; MemDout_mem←0; stay in IDLE. The pipeline advances and the instruction retires with no memory effect.
  - Valid access → MemStall=1 (combinational). Register dmem_req=1, dmem_we, dmem_addr, dmem_be, dmem_wdata; counter←0; go to WAIT.
- WAIT:
  - MemStall=1; bus outputs stable.
  - dmem_ack=1 → dmem_req←0. On a load, MemDout_mem←extend(dmem_rdata). Go to DONE.
  - No ack → counter++. When counter reaches TIMEOUT_CYCLES: dmem_req←0, MemDout_mem←0, BusErr=1 during DONE, go to DONE.
- DONE:
  - MemStall=0; EX/MEM advances at this edge.
  - Next state is IDLE; the new instruction is evaluated there.
  - dmem_ack is ignored outside WAIT.
- Latency: a zero-wait memory (ack in the first WAIT cycle) gives a 3-cycle access, with 2 stall cycles. Each extra wait cycle adds one.
- Store steering, using a = addr[1:0]:
  - SB: be = 4'b0001<<a; wdata = {4{wd[7:0]}}.
  - SH: be = a[1] ? 1100 : 0011; wdata = {2{wd[15:0]}}.
  - SW: be = 1111; wdata = wd.
- Loads: dmem_be = 1111. Extraction from dmem_rdata:
  - B/BU: select byte a; sign- or zero-extend.
  - H/HU: select half a[1]; sign- or zero-extend.
  - W: whole word.
- MemDout_mem is registered and holds its value until the next load completes or a fault/timeout clears it. Stores do not modify it.
- A reset asserted mid-WAIT drops dmem_req immediately and returns to IDLE. The bus is expected to be reset together with this block.

Test Plan:
- SW addr 0x100 data 0xDEADBEEF, ack in first WAIT → req high 1 cycle, be=1111, addr=0x100, wdata=0xDEADBEEF; MemStall high 2 cycles.
- LB addr 0x103, rdata 0x80FF_1234, ack after 3 wait cycles → MemDout_mem=0xFFFFFF80; MemStall high 5 cycles.
- LHU addr 0x102, rdata 0x8001_0000 → MemDout=0x00008001. SB addr 0x101 data 0xAB → be=0010, wdata=0xABABABAB.
- LW addr 0x102 → no dmem_req; MisalignErr one-cycle pulse; MemStall never high; MemDout=0.
- Load, ack never returned, TIMEOUT_CYCLES=4 → req drops after the 4th WAIT cycle; BusErr pulses; MemDout=0; pipeline resumes.
- Reset asserted during WAIT → dmem_req=0 and MemStall=0 immediately. A late ack is ignored, and the next load completes normally.
